vga_text_writer: RTL and testbench
==================================

Name: vga_text_writer

Overview:
- Character-stream front end for the VGA text display's write port (Line/Character/Glyph/Foreground/Background/Latch).
- Accepts bytes over a valid/ready handshake and maintains a cursor.
- Interprets CR, LF, BS and FF; issues one buffer write per Latch pulse.
- Clears lines and the screen by streaming space writes, because the text buffer cannot be read back.

Parameters:
- COLUMNS, 80, characters per line (640/8); legal range 2..128.
- LINES, 30, text lines per screen (480/16); legal range 2..32.
- BLANK_GLYPH, 8'h20, glyph written when clearing cells.
- DEFAULT_FG, 12'hFFF, foreground colour after reset.
- DEFAULT_BG, 12'h000, background colour after reset.

Ports:
- Clk  input  1  interface clock, same clock as the display write port.
- Reset  input  1  synchronous, active-high.
- Data  input  8  byte to print or control code.
- Data_Valid  input  1  Data is valid.
- Data_Ready  output  1  block can accept a byte this cycle.
- Fg_Colour  input  12  RGB 4:4:4 foreground; sampled when a byte is accepted.
- Bg_Colour  input  12  RGB 4:4:4 background; sampled when a byte is accepted.
- Line  output  5  write row.
- Character  output  7  write column.
- Glyph  output  8  glyph index.
- Foreground  output  12  write foreground colour.
- Background  output  12  write background colour.
- Latch  output  1  one-cycle write strike.
- Cursor_Line  output  5  current cursor row.
- Cursor_Col  output  7  current cursor column.

Behaviour:
- Interface: single clock Clk; Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - Latch=0, Data_Ready=0, Line=0, Character=0, Glyph=BLANK_GLYPH.
  - Foreground=DEFAULT_FG, Background=DEFAULT_BG.
  - Cursor=(0,0); colour registers take the defaults.
  - State goes to CLEAR_SCREEN.
- Reset asserted mid-operation aborts any state and restarts the full clear.
- States:
  - IDLE: Data_Ready=1. A byte is accepted on Data_Valid&Data_Ready; Fg/Bg_Colour are captured and Data_Ready drops the next cycle.
  - WRITE: single cycle. Latch=1 with Line/Character=cursor, Glyph=accepted byte and captured colours, then the cursor advances.
  - CLEAR_LINE: COLUMNS consecutive Latch cycles. Line=cursor line, Character 0..COLUMNS-1, Glyph=BLANK_GLYPH, Background=captured Bg, then IDLE.
  - CLEAR_SCREEN: LINES*COLUMNS consecutive Latch cycles in row-major order from (0,0), then IDLE with cursor (0,0).
- Byte decode (when accepted in IDLE):
  - 8'h0D CR: cursor column := 0; no write; stays in IDLE, Data_Ready held low one cycle.
  - 8'h0A LF: column := 0; line := line+1, wrapping LINES-1 -> 0; then CLEAR_LINE on the new line.
  - 8'h08 BS: if column>0, column := column-1, then WRITE BLANK_GLYPH at the new position with the cursor not advancing afterwards. At column 0 it is a no-op.
  - 8'h0C FF: CLEAR_SCREEN, using the captured Bg.
  - Any other value: printable; go to WRITE.
- Cursor advance after a printable write:
  - Column<COLUMNS-1: column+1.
  - Column=COLUMNS-1: column := 0, line := line+1 (LINES-1 wraps to 0), then CLEAR_LINE on the new line. The wrap behaves as an implicit LF.
- Latency: printable byte accepted at cycle N gives Latch at N+1 and Data_Ready=1 again at N+2, unless a wrap follows.
- Throughput: one printable byte per 2 cycles.
- Latch is never high in IDLE; Line/Character/Glyph/colours are stable whenever Latch=1.
- Data_Valid with Data_Ready=0 has no effect. The source holds Data until it is accepted.
- Cursor_Line/Cursor_Col always reflect the position of the next printable write.

Optional Feature:
- Macro: VGA_TEXT_WRITER_TAB_EN.
- Defined: 8'h09 TAB advances the cursor to the next multiple of 8 by writing BLANK_GLYPH at each skipped cell, one Latch per cycle.
  - Minimum 1 cell, maximum 8 cells.
  - Reaching COLUMNS wraps exactly as a printable wrap: column 0, next line, CLEAR_LINE.
  - Data_Ready stays low throughout.
- Undefined: 8'h09 is treated as a printable glyph.

Test Plan:
- Reset pulse -> exactly 2400 Latch pulses with Glyph=8'h20, last at (29,79). Data_Ready=1 on the cycle after the final Latch. Cursor (0,0).
- After reset, send 8'h41 with Fg=12'hF00, Bg=12'h00F -> one Latch: Line=0, Character=0, Glyph=8'h41, Foreground=12'hF00, Background=12'h00F. Cursor (0,1).
- Send 80 bytes of 8'h58 -> the 80th write lands at (0,79), followed by 80 blank Latches on line 1. Cursor (1,0).
- Move the cursor to line 29 and send 8'h0A -> 80 blank Latches on line 0. Cursor (0,0).
- Cursor (3,5): send 8'h08 -> blank written at (3,4), cursor (3,4). Cursor (3,0): send 8'h08 -> no Latch, cursor unchanged. Assert Reset mid CLEAR_LINE -> full 2400-write clear restarts.
- With TAB_EN at cursor (2,3): send 8'h09 -> 5 blank Latches at columns 3..7, cursor (2,8). Without TAB_EN: one Latch with Glyph=8'h09.

Source files
------------

// File: rtl/vga_text_writer.sv
// Character-stream front end for the VGA text buffer write port: cursor tracking,
// CR/LF/BS/FF handling and streamed blank clears. Define VGA_TEXT_WRITER_TAB_EN for TAB expansion.
//
// state          | meaning
// S_IDLE         | Data_Ready high, waiting for a byte
// S_HOLD         | byte consumed without a write (CR, BS at column 0), one dead cycle
// S_WRITE        | single Latch for a glyph or backspace blank
// S_CLEAR_LINE   | streaming blanks along the cursor line
// S_CLEAR_SCREEN | streaming blanks over the whole screen, row-major
// S_TAB          | streaming blanks up to the next tab stop
module vga_text_writer #(
    parameter int          COLUMNS     = 80,
    parameter int          LINES       = 30,
    parameter logic [7:0]  BLANK_GLYPH = 8'h20,
    parameter logic [11:0] DEFAULT_FG  = 12'hFFF,
    parameter logic [11:0] DEFAULT_BG  = 12'h000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  Data,
    input  logic        Data_Valid,
    output logic        Data_Ready,
    input  logic [11:0] Fg_Colour,
    input  logic [11:0] Bg_Colour,
    output logic [4:0]  Line,
    output logic [6:0]  Character,
    output logic [7:0]  Glyph,
    output logic [11:0] Foreground,
    output logic [11:0] Background,
    output logic        Latch,
    output logic [4:0]  Cursor_Line,
    output logic [6:0]  Cursor_Col
);

    localparam logic [6:0] LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [4:0] LAST_LINE = 5'(LINES - 1);
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
`ifdef VGA_TEXT_WRITER_TAB_EN
    localparam logic [7:0] CH_TAB = 8'h09;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WRITE,
        S_CLEAR_LINE,
        S_CLEAR_SCREEN,
        S_TAB
    } state_t;

    state_t      state, state_d;
    logic        wrap_q, wrap_d;
    logic        ready_d, latch_d;
    logic [4:0]  line_d, cur_line_d;
    logic [6:0]  char_d, cur_col_d;
    logic [7:0]  glyph_d;
    logic [11:0] fg_d, bg_d;
    logic [4:0]  cur_line_inc;

    function automatic logic [4:0] next_line(input logic [4:0] l);
        return (l == LAST_LINE) ? 5'd0 : l + 5'd1;
    endfunction

    assign cur_line_inc = next_line(Cursor_Line);

    // Output registers double as the clear counters: Line/Character hold the
    // cell being written, so the next cell is derived from them.
    always_comb begin
        state_d    = state;
        wrap_d     = wrap_q;
        ready_d    = 1'b0;
        latch_d    = 1'b0;
        line_d     = Line;
        char_d     = Character;
        glyph_d    = Glyph;
        fg_d       = Foreground;
        bg_d       = Background;
        cur_line_d = Cursor_Line;
        cur_col_d  = Cursor_Col;

        case (state)
            S_IDLE: begin
                ready_d = 1'b1;
                if (Data_Valid && Data_Ready) begin
                    ready_d = 1'b0;
                    fg_d    = Fg_Colour;
                    bg_d    = Bg_Colour;
                    line_d  = Cursor_Line;
                    char_d  = Cursor_Col;
                    glyph_d = BLANK_GLYPH;
                    case (Data)
                        CH_CR: begin
                            cur_col_d = 7'd0;
                            state_d   = S_HOLD;
                        end
                        CH_LF: begin
                            cur_line_d = cur_line_inc;
                            cur_col_d  = 7'd0;
                            line_d     = cur_line_inc;
                            char_d     = 7'd0;
                            latch_d    = 1'b1;
                            state_d    = S_CLEAR_LINE;
                        end
                        CH_BS: begin
                            if (Cursor_Col != 7'd0) begin
                                cur_col_d = Cursor_Col - 7'd1;
                                char_d    = Cursor_Col - 7'd1;
                                latch_d   = 1'b1;
                                wrap_d    = 1'b0;
                                state_d   = S_WRITE;
                            end else begin
                                state_d = S_HOLD;
                            end
                        end
                        CH_FF: begin
                            // First Latch is issued from S_CLEAR_SCREEN itself,
                            // the same start-up path used after reset.
                            cur_line_d = 5'd0;
                            cur_col_d  = 7'd0;
                            line_d     = 5'd0;
                            char_d     = 7'd0;
                            state_d    = S_CLEAR_SCREEN;
                        end
`ifdef VGA_TEXT_WRITER_TAB_EN
                        CH_TAB: begin
                            latch_d = 1'b1;
                            state_d = S_TAB;
                        end
`endif
                        default: begin
                            glyph_d = Data;
                            latch_d = 1'b1;
                            state_d = S_WRITE;
                            if (Cursor_Col == LAST_COL) begin
                                wrap_d     = 1'b1;
                                cur_col_d  = 7'd0;
                                cur_line_d = cur_line_inc;
                            end else begin
                                wrap_d    = 1'b0;
                                cur_col_d = Cursor_Col + 7'd1;
                            end
                        end
                    endcase
                end
            end

            S_HOLD: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end

            // Cursor already points at the new line when a wrap is pending.
            S_WRITE: begin
                if (wrap_q) begin
                    latch_d = 1'b1;
                    line_d  = Cursor_Line;
                    char_d  = 7'd0;
                    glyph_d = BLANK_GLYPH;
                    state_d = S_CLEAR_LINE;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_CLEAR_LINE: begin
                if (Character == LAST_COL) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    latch_d = 1'b1;
                    char_d  = Character + 7'd1;
                end
            end

            S_CLEAR_SCREEN: begin
                glyph_d = BLANK_GLYPH;
                if (!Latch) begin
                    latch_d = 1'b1;
                    line_d  = 5'd0;
                    char_d  = 7'd0;
                end else if (Character == LAST_COL) begin
                    if (Line == LAST_LINE) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        latch_d = 1'b1;
                        line_d  = Line + 5'd1;
                        char_d  = 7'd0;
                    end
                end else begin
                    latch_d = 1'b1;
                    char_d  = Character + 7'd1;
                end
            end

`ifdef VGA_TEXT_WRITER_TAB_EN
            S_TAB: begin
                if (Character == LAST_COL) begin
                    cur_line_d = cur_line_inc;
                    cur_col_d  = 7'd0;
                    line_d     = cur_line_inc;
                    char_d     = 7'd0;
                    latch_d    = 1'b1;
                    state_d    = S_CLEAR_LINE;
                end else if (Character[2:0] == 3'd7) begin
                    cur_col_d = Character + 7'd1;
                    ready_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cur_col_d = Character + 7'd1;
                    char_d    = Character + 7'd1;
                    latch_d   = 1'b1;
                end
            end
`endif

            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_CLEAR_SCREEN;
            wrap_q      <= 1'b0;
            Data_Ready  <= 1'b0;
            Latch       <= 1'b0;
            Line        <= 5'd0;
            Character   <= 7'd0;
            Glyph       <= BLANK_GLYPH;
            Foreground  <= DEFAULT_FG;
            Background  <= DEFAULT_BG;
            Cursor_Line <= 5'd0;
            Cursor_Col  <= 7'd0;
        end else begin
            state       <= state_d;
            wrap_q      <= wrap_d;
            Data_Ready  <= ready_d;
            Latch       <= latch_d;
            Line        <= line_d;
            Character   <= char_d;
            Glyph       <= glyph_d;
            Foreground  <= fg_d;
            Background  <= bg_d;
            Cursor_Line <= cur_line_d;
            Cursor_Col  <= cur_col_d;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: expected writes are queued as bytes are sent,
// a negedge monitor pops and compares every Latch.
module tb_vga_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  Data;
    logic        Data_Valid;
    logic        Data_Ready;
    logic [11:0] Fg_Colour, Bg_Colour;
    logic [4:0]  Line;
    logic [6:0]  Character;
    logic [7:0]  Glyph;
    logic [11:0] Foreground, Background;
    logic        Latch;
    logic [4:0]  Cursor_Line;
    logic [6:0]  Cursor_Col;

    vga_text_writer dut (
        .Clk(Clk), .Reset(Reset), .Data(Data), .Data_Valid(Data_Valid),
        .Data_Ready(Data_Ready), .Fg_Colour(Fg_Colour), .Bg_Colour(Bg_Colour),
        .Line(Line), .Character(Character), .Glyph(Glyph),
        .Foreground(Foreground), .Background(Background), .Latch(Latch),
        .Cursor_Line(Cursor_Line), .Cursor_Col(Cursor_Col)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  line;
        logic [6:0]  col;
        logic [7:0]  glyph;
        logic [11:0] fg;
        logic [11:0] bg;
    } wr_t;

    wr_t exp_q[$];
    wr_t got, want;
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;
    int  last_latch_cyc = 0;

    always @(posedge Clk) cyc = cyc + 1;

    always @(negedge Clk) begin
        if (Latch) begin
            got = {Line, Character, Glyph, Foreground, Background};
            compared = compared + 1;
            if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_latch: got line=%0d col=%0d glyph=%h fg=%h bg=%h, required no write",
                         got.line, got.col, got.glyph, got.fg, got.bg);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    mismatched = mismatched + 1;
                    $display("FAIL latch_write: got line=%0d col=%0d glyph=%h fg=%h bg=%h, required line=%0d col=%0d glyph=%h fg=%h bg=%h",
                             got.line, got.col, got.glyph, got.fg, got.bg,
                             want.line, want.col, want.glyph, want.fg, want.bg);
                end
            end
            last_latch_cyc = cyc;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared = compared + 1;
        if (act != exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input int l, input int c, input logic [7:0] g,
                        input logic [11:0] fg, input logic [11:0] bg);
        wr_t w;
        w.line = 5'(l); w.col = 7'(c); w.glyph = g; w.fg = fg; w.bg = bg;
        exp_q.push_back(w);
    endtask

    task automatic push_line_clear(input int l, input logic [11:0] fg, input logic [11:0] bg);
        for (int c = 0; c < COLS; c++) push(l, c, 8'h20, fg, bg);
    endtask

    task automatic push_screen_clear(input logic [11:0] fg, input logic [11:0] bg);
        for (int l = 0; l < ROWS; l++) push_line_clear(l, fg, bg);
    endtask

    // Presents a byte at a negedge and holds it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [11:0] fg, input logic [11:0] bg);
        int k;
        @(negedge Clk);
        Data = d; Fg_Colour = fg; Bg_Colour = bg; Data_Valid = 1'b1;
        k = 0;
        while (!Data_Ready && k < 5000) begin
            @(negedge Clk);
            k++;
        end
        if (!Data_Ready) check("send_timeout", 0, 1);
        @(posedge Clk);
        #1 Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        do begin
            @(negedge Clk);
            k++;
        end while (!Data_Ready && k < 5000);
        if (!Data_Ready) check({"idle_timeout_", name}, 0, 1);
        check({"pending_writes_", name}, exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string name, input int l, input int c);
        check({"cursor_line_", name}, int'(Cursor_Line), l);
        check({"cursor_col_", name}, int'(Cursor_Col), c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Data_Valid = 1'b0; Data = 8'h00;
        Fg_Colour = 12'h000; Bg_Colour = 12'h000;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_latch", int'(Latch), 0);
        check("reset_ready", int'(Data_Ready), 0);
        check("reset_glyph", int'(Glyph), 8'h20);
        check("reset_fg", int'(Foreground), 12'hFFF);
        push_screen_clear(12'hFFF, 12'h000);
        @(negedge Clk) Reset = 1'b0;

        wait_idle("power_on_clear");
        check("ready_one_after_last_latch", cyc - last_latch_cyc, 1);
        check_cursor("after_reset", 0, 0);

        // First printable: Latch one cycle after accept, ready the cycle after that.
        push(0, 0, 8'h41, 12'hF00, 12'h00F);
        send(8'h41, 12'hF00, 12'h00F);
        @(negedge Clk);
        check("latch_latency", int'(Latch), 1);
        @(negedge Clk);
        check("ready_latency", int'(Data_Ready), 1);
        check_cursor("after_A", 0, 1);

        send(8'h0D, 12'h0F0, 12'h000);
        wait_idle("cr");
        check_cursor("after_cr", 0, 0);

        for (int i = 0; i < COLS; i++) begin
            push(0, i, 8'h58, 12'h0FF, 12'h100);
            send(8'h58, 12'h0FF, 12'h100);
        end
        push_line_clear(1, 12'h0FF, 12'h100);
        wait_idle("wrap");
        check_cursor("after_wrap", 1, 0);

        for (int l = 2; l < ROWS; l++) begin
            push_line_clear(l, 12'h111, 12'h222);
            send(8'h0A, 12'h111, 12'h222);
        end
        wait_idle("lf_run");
        check_cursor("line29", 29, 0);

        push_line_clear(0, 12'h111, 12'h333);
        send(8'h0A, 12'h111, 12'h333);
        wait_idle("lf_wrap");
        check_cursor("after_lf_wrap", 0, 0);

        for (int l = 1; l <= 3; l++) begin
            push_line_clear(l, 12'h222, 12'h444);
            send(8'h0A, 12'h222, 12'h444);
        end
        send(8'h08, 12'h222, 12'h444);
        wait_idle("bs_col0");
        check_cursor("bs_col0", 3, 0);

        for (int i = 0; i < 5; i++) begin
            push(3, i, 8'(8'h61 + i), 12'h321, 12'h123);
            send(8'(8'h61 + i), 12'h321, 12'h123);
        end
        push(3, 4, 8'h20, 12'h456, 12'h789);
        send(8'h08, 12'h456, 12'h789);
        wait_idle("bs");
        check_cursor("after_bs", 3, 4);

        push_screen_clear(12'hABC, 12'h0F0);
        send(8'h0C, 12'hABC, 12'h0F0);
        wait_idle("ff");
        check_cursor("after_ff", 0, 0);

        for (int l = 1; l <= 2; l++) begin
            push_line_clear(l, 12'h555, 12'h666);
            send(8'h0A, 12'h555, 12'h666);
        end
        for (int i = 0; i < 3; i++) begin
            push(2, i, 8'(8'h31 + i), 12'h777, 12'h888);
            send(8'(8'h31 + i), 12'h777, 12'h888);
        end
`ifdef VGA_TEXT_WRITER_TAB_EN
        for (int c = 3; c < 8; c++) push(2, c, 8'h20, 12'h999, 12'hAAA);
        send(8'h09, 12'h999, 12'hAAA);
        wait_idle("tab");
        check_cursor("after_tab", 2, 8);
`else
        push(2, 3, 8'h09, 12'h999, 12'hAAA);
        send(8'h09, 12'h999, 12'hAAA);
        wait_idle("tab_glyph");
        check_cursor("after_tab_glyph", 2, 4);
`endif

        // Reset in the middle of a line clear must restart the whole-screen clear.
        push_line_clear(3, 12'h5A5, 12'hA5A);
        send(8'h0A, 12'h5A5, 12'hA5A);
        repeat (10) @(negedge Clk);
        #1;
        check("clear_line_remaining", exp_q.size(), COLS - 10);
        exp_q.delete();
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        push_screen_clear(12'hFFF, 12'h000);
        wait_idle("reset_mid_clear");
        check_cursor("after_mid_reset", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
